// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
//
// Multicycle MIPS control unit. Steps the datapath through fetch, decode and
// execute phases, one state per clock, and drives the datapath's mux selects,
// write enables and ALU operation from the current state.
//
// Memory handshake: memread/memwrite (with iord) are requests held constant
// for as long as the controller sits in FETCH, MEMRD or MEMWR; mem_ready=1
// in that cycle means the transfer completes on the coming clock edge, and
// only then does the FSM move on. mem_ready in any other state is ignored.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   op, funct   opcode / funct fields from the instruction register
//   zero        ALU zero flag (consulted only in BEQEX)
//   mem_ready   memory completes the current access this cycle
//   memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
//   alucontrol, regdst, memtoreg, regwrite
//               datapath controls
//   illegal     one-cycle pulse in DECODE on an unsupported op/funct
//   state       current FSM state, for debug
// ----------------------------------------------------------------------------
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t st;
    logic   funct_ok;
    logic   op_ok;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    // An R-type op only counts as supported when its funct is too.
    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_R:                                 op_ok = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:  op_ok = 1'b1;
            default:                              op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH:   st <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: st <= MEMADR;
                        OP_R:         st <= funct_ok ? RTYPEEX : FETCH;
                        OP_BEQ:       st <= BEQEX;
                        OP_ADDI:      st <= ADDIEX;
                        OP_J:         st <= JEX;
                        default:      st <= FETCH;
                    endcase
                end
                MEMADR:  st <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   st <= mem_ready ? MEMWB : MEMRD;
                MEMWB:   st <= FETCH;
                MEMWR:   st <= mem_ready ? FETCH : MEMWR;
                RTYPEEX: st <= RTYPEWB;
                RTYPEWB: st <= FETCH;
                BEQEX:   st <= FETCH;
                ADDIEX:  st <= ADDIWB;
                ADDIWB:  st <= FETCH;
                JEX:     st <= FETCH;
                default: st <= FETCH;
            endcase
        end
    end

    // Moore decode of the state register. The whole decode is gated by reset
    // so that an asserted reset kills requests (e.g. memwrite) immediately,
    // without waiting for the state register to be cleared by an edge.
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            case (st)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcen    = mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    illegal = ~op_ok;
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        FN_SUB:  alucontrol = ALU_SUB;
                        FN_AND:  alucontrol = ALU_AND;
                        FN_OR:   alucontrol = ALU_OR;
                        FN_SLT:  alucontrol = ALU_SLT;
                        default: alucontrol = ALU_ADD;
                    endcase
                end
                RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = zero;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWB: begin
                    regwrite = 1'b1;
                end
                JEX: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_mc_controller
//
// Table-driven check of mc_controller. Each table row is one clock cycle:
// the inputs driven during that cycle and the full set of outputs expected
// in that cycle (state plus every control). A hand-written sequence covers
// reset asserted in the middle of a store.
// ----------------------------------------------------------------------------
module tb_mc_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam logic [3:0] S_FE = 4'd0,  S_DE = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3;
    localparam logic [3:0] S_MB = 4'd4,  S_MW = 4'd5,  S_RE = 4'd6,  S_RW = 4'd7;
    localparam logic [3:0] S_BE = 4'd8,  S_AE = 4'd9,  S_AW = 4'd10, S_JE = 4'd11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, RT = 6'b000000;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       memread, memwrite, iord, irwrite, pcen;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca, regdst, memtoreg, regwrite, illegal;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .memread    (memread),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .illegal    (illegal),
        .state      (state)
    );

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    logic [5:0] sweep_fn [5];
    logic [2:0] sweep_alu[5];

    // Expected-output record; argument order follows out_t.
    function automatic out_t mk(input logic [3:0] st, input logic mr, input logic mw,
                                input logic io, input logic irw, input logic pce,
                                input logic [1:0] pcs, input logic asa, input logic [1:0] asb,
                                input logic [2:0] alu, input logic rd, input logic m2r,
                                input logic rw, input logic ill);
        out_t o;
        o.state = st;      o.memread = mr;   o.memwrite = mw;   o.iord = io;
        o.irwrite = irw;   o.pcen = pce;     o.pcsrc = pcs;     o.alusrca = asa;
        o.alusrcb = asb;   o.alucontrol = alu; o.regdst = rd;   o.memtoreg = m2r;
        o.regwrite = rw;   o.illegal = ill;
        return o;
    endfunction

    task automatic add(input logic rst, input logic [5:0] o_p, input logic [5:0] f,
                       input logic z, input logic rdy, input out_t e);
        vec_t v;
        v.rst = rst; v.op = o_p; v.fn = f; v.z = z; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic out_t actual();
        return {state, memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = actual();
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %06h (state %0d) required %06h (state %0d)",
                      name, got, got.state, exp, exp.state);
    endtask

    // Common fetch cycles: ready and stalled.
    function automatic out_t fetch_ok();
        return mk(S_FE, 1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0);
    endfunction
    function automatic out_t fetch_wait();
        return mk(S_FE, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0);
    endfunction
    function automatic out_t decode(input logic ill);
        return mk(S_DE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, ill);
    endfunction

    initial begin
        out_t idle;
        idle = mk(S_FE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0);
        sweep_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        sweep_alu = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

        // reset held: everything quiet even with mem_ready and a valid op
        add(0, LW, 0, 0, 1, idle);
        add(0, LW, 0, 0, 1, idle);
        // lw: 0,1,2,3,4
        add(1, LW, 0, 0, 1, fetch_ok());
        add(1, LW, 0, 0, 1, decode(0));
        add(1, LW, 0, 0, 1, mk(S_MA, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0));
        add(1, LW, 0, 0, 1, mk(S_MR, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        add(1, LW, 0, 0, 1, mk(S_MB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 1, 1, 0));
        // sw: 0,1,2,5
        add(1, SW, 0, 0, 1, fetch_ok());
        add(1, SW, 0, 0, 1, decode(0));
        add(1, SW, 0, 0, 1, mk(S_MA, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0));
        add(1, SW, 0, 0, 1, mk(S_MW, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        // lw with three wait cycles in FETCH and three in MEMRD
        for (int i = 0; i < 3; i++) add(1, LW, 0, 0, 0, fetch_wait());
        add(1, LW, 0, 0, 1, fetch_ok());
        add(1, LW, 0, 0, 0, decode(0));
        add(1, LW, 0, 0, 0, mk(S_MA, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            add(1, LW, 0, 0, (i == 3), mk(S_MR, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        add(1, LW, 0, 0, 1, mk(S_MB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 1, 1, 0));
        // beq taken, then not taken (mem_ready=0 in BEQEX must be ignored)
        add(1, BEQ, 0, 0, 1, fetch_ok());
        add(1, BEQ, 0, 0, 1, decode(0));
        add(1, BEQ, 0, 1, 1, mk(S_BE, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0));
        add(1, BEQ, 0, 1, 1, fetch_ok());
        add(1, BEQ, 0, 1, 1, decode(0));
        add(1, BEQ, 0, 0, 0, mk(S_BE, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0));
        // R-type funct sweep
        for (int i = 0; i < 5; i++) begin
            add(1, RT, sweep_fn[i], 0, 1, fetch_ok());
            add(1, RT, sweep_fn[i], 0, 1, decode(0));
            add(1, RT, sweep_fn[i], 0, 1,
                mk(S_RE, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, sweep_alu[i], 0, 0, 0, 0));
            add(1, RT, sweep_fn[i], 0, 1,
                mk(S_RW, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 1, 0, 1, 0));
        end
        // addi: 0,1,9,10
        add(1, ADDI, 0, 0, 1, fetch_ok());
        add(1, ADDI, 0, 0, 1, decode(0));
        add(1, ADDI, 0, 0, 1, mk(S_AE, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0));
        add(1, ADDI, 0, 0, 1, mk(S_AW, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 1, 0));
        // j: 0,1,11
        add(1, JMP, 0, 0, 1, fetch_ok());
        add(1, JMP, 0, 0, 1, decode(0));
        add(1, JMP, 0, 0, 1, mk(S_JE, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        // unsupported op, then R-type with unsupported funct
        add(1, 6'b111111, 0, 0, 1, fetch_ok());
        add(1, 6'b111111, 0, 0, 1, decode(1));
        add(1, RT, 6'b111111, 0, 1, fetch_ok());
        add(1, RT, 6'b111111, 0, 1, decode(1));
        add(1, ADDI, 0, 0, 1, fetch_ok());
        add(1, ADDI, 0, 0, 1, decode(0));

        // apply: inputs change at the falling edge, outputs sampled 1ns later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn;
            zero = vecs[i].z; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset asserted while a store is waiting on memory
        @(negedge clk); reset = 1'b0; op = SW; mem_ready = 1'b1;
        @(negedge clk); reset = 1'b1;
        #1 check("abort_fetch", fetch_ok());
        @(negedge clk); #1 check("abort_decode", decode(0));
        @(negedge clk); mem_ready = 1'b0;
        #1 check("abort_memadr", mk(S_MA, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("abort_memwr_wait", mk(S_MW, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("abort_memwr_hold", mk(S_MW, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0));
        #1 reset = 1'b0;
        #1 check("abort_reset_low", idle);
        @(negedge clk); reset = 1'b1; mem_ready = 1'b1;
        #1 check("abort_restart_fetch", fetch_ok());
        @(negedge clk); #1 check("abort_restart_decode", decode(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that sequences the MIPS datapath (PC register, register file, ALU, memory interface) over several clocks per instruction instead of one. It decodes the opcode and funct fields latched in the instruction register. Each cycle it drives the datapath's mux selects, write enables and ALU operation. It stalls on a shared instruction/data memory through a ready handshake. It sits beside the datapath in the processor top level and replaces the single-cycle combinational control.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low. Low = reset asserted.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
- irwrite  output  1  instruction register load enable.
- pcen  output  1  PC register load enable.
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALU-out register (branch target), 10 = jump target.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- regdst  output  1  destination register select: 0 = rt, 1 = rd.
- memtoreg  output  1  write-back select: 0 = ALU-out, 1 = memory data.
- regwrite  output  1  register file write enable.
- illegal  output  1  one-cycle pulse on an unsupported op or funct.
- state  output  4  current state, for debug.

## Operation
State encoding:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Codes 12-15 are unused. Next state from any of them is FETCH.

Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.

R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.

Output defaults apply in every state unless listed below:
- All enables 0 (memread, memwrite, irwrite, pcen, regwrite).
- All selects 0.
- alucontrol = 010.

Per-state outputs and transitions:
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=pcen=mem_ready. Stay until mem_ready=1, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, add (precomputes the branch target). Next state by op: lw/sw→MEMADR, R-type→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX.
- DECODE, unsupported case: an unsupported op, or an R-type with unsupported funct, pulses illegal=1 and goes to FETCH. The instruction executes as a nop; the PC has already advanced.
- MEMADR: alusrca=1, alusrcb=10, add. Next state: lw→MEMRD, sw→MEMWR.
- MEMRD: memread=1, iord=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: memwrite=1, iord=1, held steady until mem_ready=1, then go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct. Next state RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JEX: pcsrc=10, pcen=1. Next state FETCH.

Output construction: outputs are Moore decodes of state. The exceptions are irwrite, pcen and the wait transitions, which are qualified by mem_ready or zero.

## Timing
- Reset: while reset=0, state is forced to FETCH and every enable output (memread, memwrite, irwrite, pcen, regwrite, illegal) is forced to 0 combinationally. All selects read 0 and alucontrol reads 010.
- Reset release: the first FETCH request (memread=1) appears in the cycle after reset rises.
- Reset mid-instruction: the instruction is abandoned and memwrite drops without waiting for a clock edge. Execution restarts at FETCH.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait states: each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Request signals and address selects stay constant during a wait.
- irwrite and pcen pulse exactly one cycle per fetch, in the cycle mem_ready=1.
- The branch decision uses zero from the BEQEX cycle only.
- Simultaneous events: a mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- illegal lasts exactly one cycle (the DECODE cycle).

## Test plan
- Reset and release, with mem_ready=1: hold reset=0 → all enables 0, state=0. Release reset → state sequence 0,1 and memread=1 on the first cycle.
- Sequences with mem_ready=1:
  - lw → 0,1,2,3,4. regwrite=1 with memtoreg=1 only in state 4.
  - sw → 0,1,2,5. memwrite=1 for one cycle.
- Memory stall: mem_ready=0 for 3 cycles in FETCH, then 1 → memread held 4 cycles, irwrite/pcen high only on the 4th. The same check applies in MEMRD.
- beq, twice: with zero=1 → pcen=1, pcsrc=01 in state 8. With zero=0 → pcen=0. Both take 3 cycles.
- R-type sweep: funct 100000/100010/100100/100101/101010 → alucontrol 010/110/000/001/111 in RTYPEEX, then regdst=1, regwrite=1.
- Illegal and reset abort:
  - op=111111 → illegal=1 in DECODE, next state FETCH, no regwrite.
  - Reset driven low during MEMWR → memwrite falls immediately.
